// File: rtl/micro_seq_pkg.sv
// Shared constants for the microprogram sequencer.
// Holds the TY encodings and the default widths / fetch address.
package micro_seq_pkg;

    localparam int DEFAULT_ADDR_W     = 6;
    localparam int DEFAULT_FETCH_ADDR = 0;

    typedef enum logic [1:0] {
        TY_JUMP     = 2'b00,
        TY_BRANCH   = 2'b01,
        TY_CALL     = 2'b10,
        TY_DISPATCH = 2'b11
    } ty_e;

endpackage

// File: rtl/micro_return_stack.sv
// LIFO return-address stack for microsubroutine call/return.
// Ports: clk, rst (async, high), push, pop, push_data -> top, full, empty.
module micro_return_stack #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;

    assign wr_idx  = count[PTR_W-1:0];
    assign top_idx = PTR_W'(count - CNT_W'(1));
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign top     = mem[top_idx];

    // Count saturates: a push when full and a pop when empty are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address generator for the microprogrammed control unit.
// Ports: TY/NA/cond/return/opcode/stall in; ControlAddress, uPC, wait, error out.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int OPCODE_W    = 4,
    parameter int COND_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_ADDR  = DEFAULT_FETCH_ADDR
) (
    input  logic                ClockInput,
    input  logic                ResetInput,
    input  logic [1:0]          SelectionTypeTY,
    input  logic [ADDR_W-1:0]   NextAddressNA,
    input  logic [1:0]          CondSelect,
    input  logic [COND_W-1:0]   ConditionFlags,
    input  logic                MicroReturn,
    input  logic [OPCODE_W-1:0] OpcodeIn,
    input  logic                OpcodeValid,
    input  logic                Stall,
    output logic [ADDR_W-1:0]   ControlAddress,
    output logic [ADDR_W-1:0]   CurrentAddress,
    output logic                DispatchWait,
    output logic                StackError
);

    localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);

    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_full;
    logic              stack_empty;
    logic              push;
    logic              pop;
    logic              set_err;

    assign upc_inc = CurrentAddress + ADDR_W'(1);

    micro_return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (ClockInput),
        .rst       (ResetInput),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        ControlAddress = CurrentAddress;
        DispatchWait   = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        set_err        = 1'b0;
        if (ResetInput) begin
            ControlAddress = FETCH;
        end else if (Stall) begin
            ControlAddress = CurrentAddress;
        end else if (MicroReturn) begin
            if (stack_empty) begin
                ControlAddress = FETCH;
                set_err        = 1'b1;
            end else begin
                ControlAddress = stack_top;
                pop            = 1'b1;
            end
        end else begin
            unique case (ty_e'(SelectionTypeTY))
                TY_JUMP: begin
                    ControlAddress = NextAddressNA;
                end
                TY_BRANCH: begin
                    ControlAddress = ConditionFlags[CondSelect]
                                   ? NextAddressNA : upc_inc;
                end
                TY_CALL: begin
                    // A call on a full stack still jumps; the return
                    // address is lost and flagged.
                    ControlAddress = NextAddressNA;
                    push           = !stack_full;
                    set_err        = stack_full;
                end
                TY_DISPATCH: begin
                    if (OpcodeValid) begin
                        ControlAddress = NextAddressNA
                                       + ADDR_W'(OpcodeIn);
                    end else begin
                        ControlAddress = CurrentAddress;
                        DispatchWait   = 1'b1;
                    end
                end
                default: ControlAddress = CurrentAddress;
            endcase
        end
    end

    always_ff @(posedge ClockInput or posedge ResetInput) begin
        if (ResetInput) begin
            CurrentAddress <= FETCH;
            StackError     <= 1'b0;
        end else begin
            CurrentAddress <= ControlAddress;
            if (set_err) begin
                StackError <= 1'b1;
            end
        end
    end

endmodule
